// File: rtl/inv_chk_pkg.sv
// inv_chk_pkg: shared state encoding and default sizing for the inverter response checker.
package inv_chk_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_LANES = 3;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/inv_lane_cmp.sv
// inv_lane_cmp: flags a lane whose response is not the bitwise inverse of its stimulus.
module inv_lane_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] y,
    output logic             mism
);
    assign mism = (y != ~a);
endmodule

// File: rtl/inv_resp_checker.sv
// inv_resp_checker: counts per-lane inverter mismatches, tracks lane-0 code coverage and
// issues a pass/fail verdict at the end of each start/stop run.
module inv_resp_checker
    import inv_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int CNT_W = DEF_CNT_W,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int NW = $clog2(LANES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   sample_valid,
    input  logic [LANES*WIDTH-1:0] a_in,
    input  logic [LANES*WIDTH-1:0] y_in,
    output logic                   sample_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       sample_count,
    output logic [CNT_W-1:0]       err_count,
    output logic                   cov_full,
    output logic                   first_fail_valid,
    output logic [WIDTH-1:0]       first_fail_code,
    output logic [LW-1:0]          first_fail_lane
);
    chk_state_t             state;
    logic                   cap_valid;
    logic [LANES*WIDTH-1:0] cap_a, cap_y;
    logic [LANES-1:0]       mism;
    logic [NW-1:0]          nfail;
    logic [LW-1:0]          low_lane;
    logic [CNT_W:0]         err_sum;
    logic [CNT_W-1:0]       err_nxt, cnt_nxt;
    logic [2**WIDTH-1:0]    bitmap, bitmap_nxt;
    logic                   accept, clear;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        inv_lane_cmp #(.WIDTH(WIDTH)) u_cmp (
            .a   (cap_a[i*WIDTH +: WIDTH]),
            .y   (cap_y[i*WIDTH +: WIDTH]),
            .mism(mism[i])
        );
    end

    // Descending scan so the lowest failing lane is the last one written.
    always_comb begin
        nfail    = '0;
        low_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            nfail = nfail + NW'(mism[i]);
            if (mism[i]) low_lane = i[LW-1:0];
        end
    end

    assign accept     = sample_valid && state == RUN;
    assign clear      = start && (state == IDLE || state == DONE);
    assign err_sum    = {1'b0, err_count} + (CNT_W+1)'(nfail);
    assign err_nxt    = !cap_valid ? err_count : err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    assign cnt_nxt    = !cap_valid || &sample_count ? sample_count : sample_count + CNT_W'(1);
    assign bitmap_nxt = cap_valid ? bitmap | ((2**WIDTH)'(1) << cap_a[WIDTH-1:0]) : bitmap;

    assign sample_ready = state == RUN;
    assign busy         = state == RUN || state == DRAIN;
    assign done         = state == DONE;
    assign cov_full     = &bitmap;

    // The verdict uses next-state stats so a sample still in the compare stage is included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cap_valid        <= 1'b0;
            cap_a            <= '0;
            cap_y            <= '0;
            pass             <= 1'b0;
            sample_count     <= '0;
            err_count        <= '0;
            bitmap           <= '0;
            first_fail_valid <= 1'b0;
            first_fail_code  <= '0;
            first_fail_lane  <= '0;
        end else begin
            cap_valid <= accept;
            if (accept) begin
                cap_a <= a_in;
                cap_y <= y_in;
            end
            case (state)
                IDLE, DONE: if (start) state <= RUN;
                RUN:        if (stop) state <= DRAIN;
                DRAIN: begin
                    state <= DONE;
                    pass  <= err_nxt == '0 && &bitmap_nxt && cnt_nxt != '0;
                end
                default:    state <= IDLE;
            endcase
            if (clear) begin
                pass             <= 1'b0;
                sample_count     <= '0;
                err_count        <= '0;
                bitmap           <= '0;
                first_fail_valid <= 1'b0;
                first_fail_code  <= '0;
                first_fail_lane  <= '0;
            end else begin
                sample_count <= cnt_nxt;
                err_count    <= err_nxt;
                bitmap       <= bitmap_nxt;
                if (cap_valid && |mism && !first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_code  <= cap_a[WIDTH-1:0];
                    first_fail_lane  <= low_lane;
                end
            end
        end
    end
endmodule

// File: tb/tb_inv_resp_checker.sv
// tb_inv_resp_checker: directed scenarios for inv_resp_checker with hand-computed expectations.
module tb_inv_resp_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0, sample_valid = 1'b0;
    logic [11:0] a_in = '0, y_in = '0;
    logic        sample_ready, busy, done, pass, cov_full, first_fail_valid;
    logic [15:0] sample_count, err_count;
    logic [3:0]  first_fail_code;
    logic [1:0]  first_fail_lane;
    int checks = 0, failures = 0;

    inv_resp_checker dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_valid(sample_valid),
        .a_in(a_in), .y_in(y_in), .sample_ready(sample_ready), .busy(busy), .done(done),
        .pass(pass), .sample_count(sample_count), .err_count(err_count), .cov_full(cov_full),
        .first_fail_valid(first_fail_valid), .first_fail_code(first_fail_code),
        .first_fail_lane(first_fail_lane)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rep(input logic [3:0] a);
        return {a, a, a};
    endfunction

    task automatic send(input logic [11:0] a, input logic [11:0] y, input logic s);
        sample_valid = 1'b1; a_in = a; y_in = y; stop = s;
        @(negedge clk);
        sample_valid = 1'b0; stop = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sweep_good(input int n);
        for (int i = 0; i < n; i++) send(rep(4'(i)), ~rep(4'(i)), 1'b0);
    endtask

    task automatic finish_run;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 8 && !done; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout: done=%b required 1", done);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({sample_ready, busy, done, pass, cov_full, first_fail_valid} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: rdy/busy/done/pass/cov/ffv=%b required 000000",
                     {sample_ready, busy, done, pass, cov_full, first_fail_valid});
        end
        checks++;
        if ({sample_count, err_count, first_fail_code, first_fail_lane} !== 38'd0) begin
            failures++;
            $display("FAIL reset_counts: cnt=%0d err=%0d code=%0d lane=%0d required all 0",
                     sample_count, err_count, first_fail_code, first_fail_lane);
        end
    endtask

    task automatic test_all_pass;
        do_start;
        checks++;
        if ({sample_ready, busy, done} !== 3'b110) begin
            failures++;
            $display("FAIL run_flags: rdy/busy/done=%b required 110", {sample_ready, busy, done});
        end
        sweep_good(16);
        finish_run;
        checks++;
        if (pass !== 1'b1 || err_count !== 16'd0 || sample_count !== 16'd16 || cov_full !== 1'b1) begin
            failures++;
            $display("FAIL t1_all_pass: pass=%b err=%0d cnt=%0d cov=%b required 1/0/16/1",
                     pass, err_count, sample_count, cov_full);
        end
    endtask

    task automatic test_lane1_fail;
        do_start;
        for (int i = 0; i < 16; i++)
            send(rep(4'(i)), i == 5 ? {4'hA, 4'hB, 4'hA} : ~rep(4'(i)), 1'b0);
        finish_run;
        checks++;
        if (err_count !== 16'd1 || sample_count !== 16'd16 || pass !== 1'b0) begin
            failures++;
            $display("FAIL t2_counts: err=%0d cnt=%0d pass=%b required 1/16/0",
                     err_count, sample_count, pass);
        end
        checks++;
        if (first_fail_valid !== 1'b1 || first_fail_code !== 4'd5 || first_fail_lane !== 2'd1) begin
            failures++;
            $display("FAIL t2_first_fail: v=%b code=%0d lane=%0d required 1/5/1",
                     first_fail_valid, first_fail_code, first_fail_lane);
        end
    endtask

    task automatic test_partial;
        do_start;
        sweep_good(8);
        finish_run;
        checks++;
        if (cov_full !== 1'b0 || pass !== 1'b0 || sample_count !== 16'd8 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL t3_partial: cov=%b pass=%b cnt=%0d err=%0d required 0/0/8/0",
                     cov_full, pass, sample_count, err_count);
        end
    endtask

    task automatic test_idle_ignore;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) send(rep(4'(i)), ~rep(4'(i)), 1'b0);
        checks++;
        if (sample_count !== 16'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t4_idle_cnt: cnt=%0d busy=%b required 0/0", sample_count, busy);
        end
        do_start;
        finish_run;
        checks++;
        if (sample_count !== 16'd0 || pass !== 1'b0) begin
            failures++;
            $display("FAIL t4_empty_run: cnt=%0d pass=%b required 0/0", sample_count, pass);
        end
    endtask

    task automatic test_multi_fail;
        do_start;
        send(rep(4'd3), {4'h0, ~4'd3, 4'hF}, 1'b0);
        checks++;
        if (sample_count !== 16'd0) begin
            failures++;
            $display("FAIL t5_latency: cnt=%0d required 0 one cycle after accept", sample_count);
        end
        @(negedge clk);
        checks++;
        if (err_count !== 16'd2 || first_fail_lane !== 2'd0 || first_fail_code !== 4'd3) begin
            failures++;
            $display("FAIL t5_two_lanes: err=%0d lane=%0d code=%0d required 2/0/3",
                     err_count, first_fail_lane, first_fail_code);
        end
        send(rep(4'd9), {4'h9, ~4'd9, ~4'd9}, 1'b0);
        finish_run;
        checks++;
        if (err_count !== 16'd3 || first_fail_code !== 4'd3 || first_fail_lane !== 2'd0
            || sample_count !== 16'd2) begin
            failures++;
            $display("FAIL t5_sticky: err=%0d code=%0d lane=%0d cnt=%0d required 3/3/0/2",
                     err_count, first_fail_code, first_fail_lane, sample_count);
        end
    endtask

    task automatic test_reset_mid_run;
        do_start;
        sweep_good(6);
        send(rep(4'd6), ~rep(4'd6), 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass, first_fail_valid} !== 4'b0 || sample_count !== 16'd0
            || err_count !== 16'd0) begin
            failures++;
            $display("FAIL t6_async_reset: busy/done/pass/ffv=%b cnt=%0d err=%0d required 0",
                     {busy, done, pass, first_fail_valid}, sample_count, err_count);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (sample_count !== 16'd0 || sample_ready !== 1'b0) begin
            failures++;
            $display("FAIL t6_discard: cnt=%0d rdy=%b required 0/0", sample_count, sample_ready);
        end
        do_start;
        sweep_good(16);
        finish_run;
        checks++;
        if (sample_count !== 16'd16 || pass !== 1'b1) begin
            failures++;
            $display("FAIL t6_rerun: cnt=%0d pass=%b required 16/1", sample_count, pass);
        end
    endtask

    task automatic test_stop_with_sample;
        do_start;
        sweep_good(15);
        send(rep(4'd15), ~rep(4'd15), 1'b1);
        for (int i = 0; i < 8 && !done; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || sample_count !== 16'd16 || pass !== 1'b1 || cov_full !== 1'b1) begin
            failures++;
            $display("FAIL stop_with_sample: done=%b cnt=%0d pass=%b cov=%b required 1/16/1/1",
                     done, sample_count, pass, cov_full);
        end
    endtask

    task automatic test_start_stop_same;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        checks++;
        if (sample_ready !== 1'b1 || pass !== 1'b0 || sample_count !== 16'd0) begin
            failures++;
            $display("FAIL start_stop_same: rdy=%b pass=%b cnt=%0d required 1/0/0",
                     sample_ready, pass, sample_count);
        end
        finish_run;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        test_reset;
        reset = 1'b0;
        @(negedge clk);
        test_all_pass;
        test_lane1_fail;
        test_partial;
        test_idle_ignore;
        test_multi_fail;
        test_reset_mid_run;
        test_stop_with_sample;
        test_start_stop_same;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
